// File: rtl/mux_pkg.sv
// Shared constants for the stream arbiter: arbitration modes and select-width helper.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic: fixed lowest-index priority or round-robin from ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int MODE = MODE_FIXED,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [NCH-1:0] at_or_above;
  logic [NCH-1:0] req_hi;
  logic [NCH-1:0] grant_hi;
  logic [NCH-1:0] grant_lo;
  logic [NCH-1:0] grant_raw;
  logic [NCH:0]   hi_chain;
  logic [NCH:0]   lo_chain;
  logic [SEL_W-1:0] idx_chain [NCH+1];

  assign hi_chain[0]  = 1'b0;
  assign lo_chain[0]  = 1'b0;
  assign idx_chain[0] = '0;

  // Round-robin first searches channels at or above ptr, then wraps to the lowest.
  assign req_hi = (MODE == MODE_RR) ? (req & at_or_above) : '0;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign at_or_above[gi] = (SEL_W'(gi) >= ptr);
      assign grant_hi[gi]    = req_hi[gi] & ~hi_chain[gi];
      assign grant_lo[gi]    = req[gi] & ~lo_chain[gi];
      assign hi_chain[gi+1]  = hi_chain[gi] | req_hi[gi];
      assign lo_chain[gi+1]  = lo_chain[gi] | req[gi];
      assign idx_chain[gi+1] = idx_chain[gi] | ({SEL_W{grant[gi]}} & SEL_W'(gi));
    end
  endgenerate

  assign grant_raw = hi_chain[NCH] ? grant_hi : grant_lo;
  assign grant     = (en && lo_chain[NCH]) ? grant_raw : '0;
  assign grant_idx = idx_chain[NCH];

endmodule

// File: rtl/mux_stream_arb.sv
// N-channel valid/ready stream arbiter with a single registered output stage.
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int MODE  = MODE_FIXED,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
);

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [SEL_W-1:0] rr_ptr_reg;
  logic [SEL_W-1:0] rr_ptr_next;
  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             in_xfer;
  logic [WIDTH-1:0] data_chain [NCH+1];

  // Accept only while the output slot is empty or draining, never during reset.
  assign load_en = !out_valid_reg || out_ready;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_reg),
    .en        (load_en && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready = grant;
  assign in_xfer  = |grant;

  assign data_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_data
      assign data_chain[gi+1] = data_chain[gi] |
                                ({WIDTH{grant[gi]}} & in_data[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (MODE == MODE_RR && in_xfer) begin
      rr_ptr_next = (grant_idx == SEL_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (in_xfer) begin
        out_data_reg  <= data_chain[NCH];
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench: fixed-priority 2-channel and round-robin 4-channel instances.
module tb_mux_stream_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] f_in_data;
  logic [1:0]  f_in_valid;
  logic [1:0]  f_in_ready;
  logic [7:0]  f_out_data;
  logic        f_out_valid;
  logic        f_out_ready;
  logic [0:0]  f_out_sel;

  logic [31:0] r_in_data;
  logic [3:0]  r_in_valid;
  logic [3:0]  r_in_ready;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_ready;
  logic [1:0]  r_out_sel;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux_stream_arb #(.WIDTH(8), .NCH(2), .MODE(0)) dut_fix (
    .clk(clk), .rst(rst),
    .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_sel(f_out_sel)
  );

  mux_stream_arb #(.WIDTH(8), .NCH(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .in_data(r_in_data), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_sel(r_out_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    f_in_data = 16'h2211; f_in_valid = 2'b11; f_out_ready = 1'b1;
    r_in_data = 32'hA3A2A1A0; r_in_valid = 4'hF; r_out_ready = 1'b1;

    // Reset state with inputs already valid
    #1;
    check("rst_f_valid", f_out_valid, 0);
    check("rst_f_data", f_out_data, 0);
    check("rst_f_ready", f_in_ready, 0);
    check("rst_r_valid", r_out_valid, 0);
    check("rst_r_sel", r_out_sel, 0);
    check("rst_r_ready", r_in_ready, 0);
    r_in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fix_ready_first", f_in_ready, 2'b01);

    // Fixed priority: ch0 always wins while valid
    for (int k = 0; k < 4; k++) begin
      step();
      check("fix_data", f_out_data, 8'h11);
      check("fix_sel", f_out_sel, 0);
      check("fix_ready", f_in_ready, 2'b01);
    end
    f_in_valid = 2'b10;
    step();
    check("fix_ch1_data", f_out_data, 8'h22);
    check("fix_ch1_sel", f_out_sel, 1);

    // Backpressure holds the word and blocks all inputs
    f_in_data = 16'h005A; f_in_valid = 2'b01;
    step();
    check("bp_load", f_out_data, 8'h5A);
    f_out_ready = 1'b0;
    f_in_data = 16'h0077;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", f_in_ready, 0);
      step();
      check("bp_hold", f_out_data, 8'h5A);
      check("bp_valid", f_out_valid, 1);
    end
    f_out_ready = 1'b1;
    #1;
    check("bp_release_ready", f_in_ready, 2'b01);
    step();
    check("bp_next", f_out_data, 8'h77);
    f_in_valid = 2'b00;

    // Full throughput from ch2 only
    for (int k = 1; k <= 8; k++) begin
      r_in_data = {8'h00, 8'(k), 16'h0000};
      r_in_valid = 4'b0100;
      step();
      check("tp_data", r_out_data, k);
      check("tp_sel", r_out_sel, 2);
      check("tp_valid", r_out_valid, 1);
    end

    // Hold the last word, then reset between edges
    r_in_valid = 4'h0; r_out_ready = 1'b0;
    step();
    check("hold_pre_rst", r_out_data, 8'h08);
    #2;
    rst = 1'b1;
    r_in_data = 32'hA3A2A1A0; r_in_valid = 4'hF; r_out_ready = 1'b1;
    #1;
    check("mid_rst_valid", r_out_valid, 0);
    check("mid_rst_data", r_out_data, 0);
    check("mid_rst_ready", r_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin rotation from ptr 0
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_sel", r_out_sel, k % 4);
      check("rr_data", r_out_data, 8'hA0 + (k % 4));
    end

    // Idle keeps the pointer (now 1)
    r_in_valid = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("idle_valid", r_out_valid, 0);
    end
    r_in_valid = 4'hF;
    step();
    check("idle_ptr_sel", r_out_sel, 1);
    check("idle_ptr_data", r_out_data, 8'hA1);

    // Wrap search: ptr 2, only ch0 valid
    r_in_valid = 4'b0001;
    step();
    check("wrap_sel", r_out_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
